// File: rtl/signed_pair_accum.sv
// Windowed saturating accumulator for the signed sample pair from the autoinst_signed/sub stage.
// Each window's sum, sample count and active-low overflow flag are presented on a valid/ready output.
module signed_pair_accum #(
    parameter int WIDTH_ACC = 8,
    parameter int WINDOW    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [1:0]           an_outputpre,
    input  logic signed [1:0]           another_output,
    input  logic        [1:0]           an_output2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_ACC-1:0] sum_out,
    output logic        [7:0]           sum_cnt,
    output logic                        ovf_l
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};
    localparam logic [7:0]           WINDOW_CNT = 8'(WINDOW);

    state_t                      state_r;
    logic signed [WIDTH_ACC-1:0] acc_r;
    logic        [7:0]           cnt_r;
    logic                        sat_r;

    logic                        accept_s;
    logic                        close_s;
    logic                        clamp_s;
    logic signed [WIDTH_ACC-1:0] a_ext_s;
    logic signed [WIDTH_ACC-1:0] b_ext_s;
    logic signed [WIDTH_ACC-1:0] term_s;
    logic signed [WIDTH_ACC-1:0] base_acc_s;
    logic signed [WIDTH_ACC-1:0] next_acc_s;
    logic        [7:0]           next_cnt_s;
    logic        [WIDTH_ACC:0]   add_res_s;

    // Returns {clamp, result}; overflow shows up as disagreement of the two top bits of the widened sum.
    function automatic logic [WIDTH_ACC:0] sat_add(
        input logic [WIDTH_ACC-1:0] a,
        input logic [WIDTH_ACC-1:0] b
    );
        logic [WIDTH_ACC:0]   wide;
        logic [WIDTH_ACC-1:0] res;
        logic                 clamp;
        wide  = {a[WIDTH_ACC-1], a} + {b[WIDTH_ACC-1], b};
        clamp = (wide[WIDTH_ACC] != wide[WIDTH_ACC-1]);
        if (clamp) begin
            res = wide[WIDTH_ACC] ? ACC_MIN : ACC_MAX;
        end else begin
            res = wide[WIDTH_ACC-1:0];
        end
        return {clamp, res};
    endfunction

    assign in_ready = (state_r != HOLD);

    // Next-step accumulator, count and window-close decision for the sample on the input.
    always_comb begin
        accept_s = in_valid && (state_r != HOLD);
        a_ext_s  = {{(WIDTH_ACC-2){an_outputpre[1]}}, an_outputpre};
        b_ext_s  = {{(WIDTH_ACC-2){another_output[1]}}, another_output};
        if (an_output2[0]) begin
            term_s = a_ext_s + b_ext_s;
        end else begin
            term_s = {WIDTH_ACC{1'b0}};
        end
        if (state_r == IDLE) begin
            base_acc_s = {WIDTH_ACC{1'b0}};
            next_cnt_s = 8'd1;
        end else begin
            base_acc_s = acc_r;
            next_cnt_s = cnt_r + 8'd1;
        end
        add_res_s  = sat_add(base_acc_s, term_s);
        clamp_s    = add_res_s[WIDTH_ACC];
        next_acc_s = add_res_s[WIDTH_ACC-1:0];
        close_s    = (next_cnt_s == WINDOW_CNT) || an_output2[1];
    end

    // Window FSM with the result registers loaded on the edge that closes the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            acc_r     <= {WIDTH_ACC{1'b0}};
            cnt_r     <= 8'd0;
            sat_r     <= 1'b0;
            sum_out   <= {WIDTH_ACC{1'b0}};
            sum_cnt   <= 8'd0;
            out_valid <= 1'b0;
            ovf_l     <= 1'b1;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        acc_r <= next_acc_s;
                        cnt_r <= next_cnt_s;
                        sat_r <= sat_r | clamp_s;
                        if (close_s) begin
                            state_r   <= HOLD;
                            out_valid <= 1'b1;
                            sum_out   <= next_acc_s;
                            sum_cnt   <= next_cnt_s;
                            ovf_l     <= ~(sat_r | clamp_s);
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        acc_r     <= {WIDTH_ACC{1'b0}};
                        cnt_r     <= 8'd0;
                        sat_r     <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    acc_r     <= {WIDTH_ACC{1'b0}};
                    cnt_r     <= 8'd0;
                    sat_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_pair_accum.sv
// Drives one sample stream into an 8-bit and a 4-bit accumulator (both WINDOW=4) and
// compares every emitted window result against a queue of expected results.
module tb_signed_pair_accum;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic signed [1:0] an_outputpre;
    logic signed [1:0] another_output;
    logic        [1:0] an_output2;
    logic              out_ready;

    logic              in_ready_a, in_ready_b;
    logic              out_valid_a, out_valid_b;
    logic signed [7:0] sum_out_a;
    logic signed [3:0] sum_out_b;
    logic        [7:0] sum_cnt_a, sum_cnt_b;
    logic              ovf_l_a, ovf_l_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a; int b; int ctl; int cl;
        int s8; int s4; int cnt; int o8; int o4;
    } vec_t;

    typedef struct {
        int s8; int s4; int cnt; int o8; int o4;
    } exp_t;

    vec_t vecs[28];
    int   nvec = 0;
    exp_t sb_q[$];

    signed_pair_accum #(.WIDTH_ACC(8), .WINDOW(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .an_outputpre(an_outputpre), .another_output(another_output), .an_output2(an_output2),
        .out_valid(out_valid_a), .out_ready(out_ready), .sum_out(sum_out_a),
        .sum_cnt(sum_cnt_a), .ovf_l(ovf_l_a)
    );

    signed_pair_accum #(.WIDTH_ACC(4), .WINDOW(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .an_outputpre(an_outputpre), .another_output(another_output), .an_output2(an_output2),
        .out_valid(out_valid_b), .out_ready(out_ready), .sum_out(sum_out_b),
        .sum_cnt(sum_cnt_b), .ovf_l(ovf_l_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int a, input int b, input int ctl, input int cl,
                       input int s8, input int s4, input int cnt, input int o8, input int o4);
        vecs[nvec] = '{a: a, b: b, ctl: ctl, cl: cl, s8: s8, s4: s4, cnt: cnt, o8: o8, o4: o4};
        nvec++;
    endtask

    // Pop the oldest expectation and compare it against both result ports.
    task automatic check_result();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("sum_out_w8", int'(sum_out_a), e.s8);
            chk("sum_out_w4", int'(sum_out_b), e.s4);
            chk("sum_cnt_w8", int'(sum_cnt_a), e.cnt);
            chk("sum_cnt_w4", int'(sum_cnt_b), e.cnt);
            chk("ovf_l_w8", int'(ovf_l_a), e.o8);
            chk("ovf_l_w4", int'(ovf_l_b), e.o4);
            chk("in_ready_hold", int'({in_ready_a, in_ready_b}), 0);
        end
    endtask

    // Drive one sample, leaving in_valid high afterwards.
    task automatic send(input vec_t v);
        @(negedge clk);
        in_valid       = 1'b1;
        an_outputpre   = 2'(v.a);
        another_output = 2'(v.b);
        an_output2     = 2'(v.ctl);
        chk("in_ready_before_accept", int'({in_ready_a, in_ready_b}), 3);
        if (v.cl != 0) begin
            sb_q.push_back('{s8: v.s8, s4: v.s4, cnt: v.cnt, o8: v.o8, o4: v.o4});
        end
        @(posedge clk);
        #1;
        chk("out_valid_after_accept", int'({out_valid_a, out_valid_b}), (v.cl != 0) ? 3 : 0);
        if (out_valid_a || out_valid_b) begin
            check_result();
        end
    endtask

    task automatic send_s(input int a, input int b, input int ctl, input int cl,
                          input int s8, input int s4, input int cnt, input int o8, input int o4);
        vec_t v;
        v = '{a: a, b: b, ctl: ctl, cl: cl, s8: s8, s4: s4, cnt: cnt, o8: o8, o4: o4};
        send(v);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid_after_ack", int'({out_valid_a, out_valid_b}), 0);
        chk("in_ready_after_ack", int'({in_ready_a, in_ready_b}), 3);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        an_outputpre = 2'sd0; another_output = 2'sd0; an_output2 = 2'd0;

        // w8 sum, w4 sum, cnt, w8 ovf_l, w4 ovf_l are only meaningful on closing samples
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 8, 7, 4, 1, 0);
        for (int i = 0; i < 3; i++) add(-2, -2, 1, 0, 0, 0, 0, 0, 0);
        add(-2, -2, 1, 1, -16, -8, 4, 1, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 8, 7, 4, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 4, 4, 4, 1, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(-2, -2, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 3, 1, 3, 3, 3, 1, 1);
        add(-2, 1, 3, 1, -1, -1, 1, 1, 1);
        for (int i = 0; i < 3; i++) add(-2, -2, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, -10, -6, 4, 1, 0);
        for (int i = 0; i < 3; i++) add(-2, -2, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 4, 1, 1);

        #2 reset = 1'b1;
        #1;
        chk("reset_out_valid", int'({out_valid_a, out_valid_b}), 0);
        chk("reset_sum_out", int'(sum_out_a) + int'(sum_out_b), 0);
        chk("reset_sum_cnt", int'(sum_cnt_a) + int'(sum_cnt_b), 0);
        chk("reset_ovf_l", int'({ovf_l_a, ovf_l_b}), 3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", int'({in_ready_a, in_ready_b}), 3);

        for (int i = 0; i < nvec; i++) begin
            send(vecs[i]);
            if (vecs[i].cl != 0) handshake();
        end

        // Backpressure: result held for 5 cycles with in_valid high throughout.
        for (int i = 0; i < 3; i++) send_s(1, 1, 1, 0, 0, 0, 0, 0, 0);
        send_s(1, 1, 1, 1, 8, 7, 4, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", int'({in_ready_a, in_ready_b}), 0);
            chk("bp_out_valid", int'({out_valid_a, out_valid_b}), 3);
            chk("bp_sum_out", int'(sum_out_a), 8);
            chk("bp_sum_cnt", int'(sum_cnt_b), 4);
        end
        @(negedge clk);
        out_ready = 1'b1;
        an_outputpre = 2'sd1; another_output = 2'sd0; an_output2 = 2'd3;
        @(posedge clk);
        #1;
        chk("bp_ack_out_valid", int'({out_valid_a, out_valid_b}), 0);
        chk("bp_ack_in_ready", int'({in_ready_a, in_ready_b}), 3);
        @(negedge clk);
        out_ready = 1'b0;
        sb_q.push_back('{s8: 1, s4: 1, cnt: 1, o8: 1, o4: 1});
        @(posedge clk);
        #1;
        chk("bp_fresh_out_valid", int'({out_valid_a, out_valid_b}), 3);
        if (out_valid_a || out_valid_b) check_result();
        handshake();

        // Asynchronous reset mid-cycle while a saturated result is held.
        for (int i = 0; i < 3; i++) send_s(1, 1, 1, 0, 0, 0, 0, 0, 0);
        send_s(1, 1, 1, 1, 8, 7, 4, 1, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("hold_reset_out_valid", int'({out_valid_a, out_valid_b}), 0);
        chk("hold_reset_sum_out", int'(sum_out_a) + int'(sum_out_b), 0);
        chk("hold_reset_sum_cnt", int'(sum_cnt_a) + int'(sum_cnt_b), 0);
        chk("hold_reset_ovf_l", int'({ovf_l_a, ovf_l_b}), 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("hold_reset_in_ready", int'({in_ready_a, in_ready_b}), 3);

        // Reset pulse mid-window discards the partial window.
        send_s(1, 1, 1, 0, 0, 0, 0, 0, 0);
        send_s(1, 1, 1, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midwin_no_result", int'({out_valid_a, out_valid_b}), 0);
        chk("midwin_in_ready", int'({in_ready_a, in_ready_b}), 3);

        // out_ready outside HOLD is ignored; idle gaps in ACCUM hold state.
        out_ready = 1'b1;
        send_s(1, 0, 1, 0, 0, 0, 0, 0, 0);
        send_s(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("gap_out_valid", int'({out_valid_a, out_valid_b}), 0);
        end
        send_s(1, 0, 1, 0, 0, 0, 0, 0, 0);
        send_s(1, 0, 1, 1, 4, 4, 4, 1, 1);
        handshake();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
